// File: rtl/serial_deserializer_pkg.sv
// rtl/serial_deserializer_pkg.sv - shared constants and state encoding for the serial deserializer
package serial_deserializer_pkg;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  typedef enum logic {
    SHIFT = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// rtl/serial_deserializer_if.sv - serial-in / parallel-out handshake bundle
interface serial_deserializer_if #(
  parameter int W = serial_deserializer_pkg::W
);

  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/serial_deserializer_bit_counter.sv
// rtl/serial_deserializer_bit_counter.sv - bit counter with enable, sync clear and terminal count at W-1
module deser_bit_counter #(
  parameter int W  = serial_deserializer_pkg::W,
  parameter int CW = serial_deserializer_pkg::CW
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count;
  logic [CW-1:0] count_d;

  assign tc = (count == CW'(W - 1));

  // Wrap on the terminal count so W need not be a power of two.
  always_comb begin
    count_d = count;
    if (en) begin
      count_d = tc ? '0 : count + 1'b1;
    end
  end

  deser_dff #(.WIDTH(CW)) u_count (
    .clk   (clk),
    .reset (clr),
    .d     (count_d),
    .q     (count)
  );

endmodule

// File: rtl/serial_deserializer_dff.sv
// rtl/serial_deserializer_dff.sv - D flip-flop cell with synchronous reset gated onto D
module deser_dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d_gated;

  assign d_gated = reset ? '0 : d;

  always_ff @(posedge clk) begin
    q <= d_gated;
  end

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - LSB-first serial to parallel word assembler with valid/ready output
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int W  = serial_deserializer_pkg::W,
  parameter int CW = serial_deserializer_pkg::CW
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_deserializer_if.slave    bus
);

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic         tc;
  logic [W-1:0] sreg;
  logic [W-1:0] sreg_d;

  // Bits are only taken while collecting; in FULL in_bit is ignored.
  assign accept = bus.in_valid && (state == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHIFT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SHIFT:   if (accept && tc) state_next = FULL;
      FULL:    if (bus.out_ready) state_next = SHIFT;
      default: state_next = SHIFT;
    endcase
  end

  assign sreg_d = accept ? {bus.in_bit, sreg[W-1:1]} : sreg;

  deser_dff #(.WIDTH(W)) u_sreg (
    .clk   (clk),
    .reset (reset),
    .d     (sreg_d),
    .q     (sreg)
  );

  deser_bit_counter #(.W(W), .CW(CW)) u_bit_counter (
    .clk (clk),
    .clr (reset),
    .en  (accept),
    .tc  (tc)
  );

  assign bus.out_valid = (state == FULL);
  assign bus.in_ready  = (state != FULL);
  assign bus.out_data  = sreg;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - scoreboard bench for serial_deserializer
module tb_serial_deserializer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_deserializer_if bus ();

  serial_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks     = 0;
  int         failures   = 0;
  int         pulses     = 0;
  int         pulses_ref = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_w;
  logic [7:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.out_valid === 1'b1 && valid_prev !== 1'b1) pulses++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h required=none", bus.out_data);
        end else begin
          exp_w = expq.pop_front();
          chk("word", 32'(bus.out_data), 32'(exp_w));
        end
      end
    end
    valid_prev = bus.out_valid;
  end

  task automatic send_word(input logic [7:0] w, input bit gap);
    int guard;
    bit acc;
    expq.push_back(w);
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      bus.in_bit   = w[i];
      bus.in_valid = 1'b1;
      do begin
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("accept_timeout", 0, 1);
      if (i == 6) chk("no_early_valid", 32'(bus.out_valid), 0);
      if (gap && i != 7) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    chk("valid_latency", 32'(bus.out_valid), 1);
  endtask

  task automatic release_word();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 0);
    chk("release_in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_data", 32'(bus.out_data), 0);
    reset = 1'b0;

    // 1,0,1,0,0,1,0,1 LSB-first on consecutive cycles
    send_word(8'hA5, 1'b0);
    chk("full_data", 32'(bus.out_data), 32'hA5);
    chk("full_in_ready", 32'(bus.in_ready), 0);

    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_bit   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("hold_data", 32'(bus.out_data), 32'hA5);
      chk("hold_valid", 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    release_word();

    send_word(8'hFF, 1'b1);
    chk("gapped_data", 32'(bus.out_data), 32'hFF);

    // handoff cycle presents a bit that must not be taken
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("handoff_valid", 32'(bus.out_valid), 0);
    send_word(8'h3C, 1'b0);
    chk("handoff_next_data", 32'(bus.out_data), 32'h3C);
    release_word();

    for (int i = 0; i < 4; i++) begin
      bus.in_bit   = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("midreset_out_valid", 32'(bus.out_valid), 0);
    chk("midreset_out_data", 32'(bus.out_data), 0);
    chk("midreset_in_ready", 32'(bus.in_ready), 1);
    send_word(8'h81, 1'b0);
    chk("after_reset_data", 32'(bus.out_data), 32'h81);
    release_word();

    pulses_ref    = pulses;
    bus.out_ready = 1'b1;
    send_word(8'h55, 1'b0);
    send_word(8'hAA, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("b2b_pulses", 32'(pulses - pulses_ref), 2);
    chk("b2b_valid_after", 32'(bus.out_valid), 0);
    chk("queue_drained", 32'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter: W, default 8, word width in bits; legal values 2..32.
REQ-002 Parameter: CW, default 3, counter width; SHALL equal ceil(log2(W)).
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_bit  input  1  serial data bit, LSB-first.
REQ-006 Port: in_valid  input  1  in_bit carries a valid bit this cycle.
REQ-007 Port: in_ready  output  1  block accepts a bit this cycle.
REQ-008 Port: out_data  output  W  assembled parallel word.
REQ-009 Port: out_valid  output  1  out_data holds a complete word.
REQ-010 Port: out_ready  input  1  consumer takes the word this cycle.

Function
REQ-011 Two states SHALL exist: SHIFT (collecting bits) and FULL (word held).
REQ-012 in_ready SHALL equal NOT out_valid, combinationally.
REQ-013 A bit SHALL be accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-014 On accept, the shift register SHALL shift right by one, with in_bit loaded into bit W-1.
REQ-015 On accept, the bit counter SHALL increment.
REQ-016 in_valid=0 in SHIFT SHALL hold the counter and the shift register unchanged.
REQ-017 The accept that brings the count to W SHALL move the block to FULL: count wraps to 0 and out_valid=1 from the next cycle (latency 1 cycle after the Wth bit).
REQ-018 After W accepts, the first bit received SHALL be at out_data[0] and the last at out_data[W-1].
REQ-019 In FULL, out_data SHALL be stable and in_bit SHALL be ignored regardless of in_valid.
REQ-020 In FULL with out_ready=1, the block SHALL return to SHIFT on that edge, and out_valid SHALL deassert the next cycle.
REQ-021 in_valid and out_ready both asserted in FULL SHALL complete the handoff only; no bit is accepted that cycle.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 out_data SHALL be don't-care-stable in SHIFT (partial word visible); consumers use it only when out_valid=1.

Reset
REQ-024 reset=1 at a clock edge SHALL clear the counter to 0, out_data to 0 and out_valid to 0, and select SHIFT; in_ready is then 1.
REQ-025 Reset SHALL override every other input on the same edge.
REQ-026 Reset mid-word SHALL discard the partial bits; reset in FULL SHALL drop the held word.

Structure
REQ-027 W, CW and the SHIFT/FULL state encoding SHALL reside in the shared constants package/include, next to the storage element definitions.
REQ-028 One sub-module, deser_bit_counter (CW-bit synchronous counter with enable, synchronous clear and a terminal-count output at W-1), SHALL be instantiated.
REQ-029 Storage SHALL use the codebase's D flip-flop cells, clocked on clk, with synchronous reset gating on the D inputs.

Verification
REQ-030 Reset, then feed 1,0,1,0,0,1,0,1 with in_valid=1 on 8 consecutive cycles and out_ready=0 -> out_valid=1 one cycle after the 8th bit, out_data=0xA5, in_ready=0.
REQ-031 Hold FULL for 5 cycles while toggling in_bit/in_valid -> out_data remains 0xA5; raise out_ready for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
REQ-032 Send 8 bits of 0xFF with in_valid=0 gaps after every bit -> out_data=0xFF after the 8th accept; no extra bits are counted.
REQ-033 Assert in_valid and out_ready together in FULL, then send 0x3C -> the next word is 0x3C and is not shifted by the bit presented during the handoff cycle.
REQ-034 Assert reset after 4 bits of a word, then send 0x81 -> out_data=0x81 and out_valid occurs exactly 8 accepts after reset.
REQ-035 Send back-to-back words 0x55 then 0xAA, with out_ready=1 each cycle out_valid is high -> the two words appear in order, with one out_valid pulse per word.
